// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and frame-length helper for the UART transceiver.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_e;

    // Frame length in clk cycles, start bit through last stop bit.
    function automatic int frame_cycles(input int data_bits, input parity_e parity_mode,
                                        input int stop_bits, input int clks_per_bit);
        int par_bits;
        par_bits = (parity_mode == PAR_NONE) ? 0 : 1;
        return (1 + data_bits + par_bits + stop_bits) * clks_per_bit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_bit_timer
// Description : Loadable down-counter; ticks once per bit period. Loading the
//               half value places the first tick at bit centre.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic load_half,
    output logic tick
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] c_full_count = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_half_count = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_half ? c_half_count : c_full_count;
        end else if (r_count == '0) begin
            r_count <= c_full_count;
        end else begin
            r_count <= r_count - 1'b1;
        end
    end

    // Not gated by load: the TX ready path feeds load, so gating would loop.
    assign tick = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/uart_xcvr.sv
`default_nettype none
// ============================================================================
// Module      : uart_xcvr
// Description : Parametrised full-duplex UART transceiver with valid/ready TX
//               and registered RX error reporting. Define UART_RX_SYNC_EN to
//               insert a two-flop synchronizer on rx.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module uart_xcvr
    import uart_pkg::*;
#(
    parameter int      DATA_BITS    = 8,
    parameter int      CLKS_PER_BIT = 16,
    parameter parity_e PARITY_MODE  = PAR_EVEN,
    parameter int      STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_en,
    input  logic                 rx_en,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_ready,
    output logic                 parity_error,
    output logic                 stop_error
);
    localparam int BIT_CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [BIT_CNT_W-1:0] c_last_data = BIT_CNT_W'(DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] c_last_stop = BIT_CNT_W'(STOP_BITS);
    localparam logic c_has_parity = (PARITY_MODE != PAR_NONE);
    localparam logic c_odd        = (PARITY_MODE == PAR_ODD);

    tx_state_e            r_tx_state, w_tx_state_nxt;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_nxt;
    logic [BIT_CNT_W-1:0] r_tx_cnt, w_tx_cnt_nxt;
    logic                 r_tx, w_tx_nxt, r_tx_par, w_tx_par_nxt;
    logic                 w_tx_tick, w_tx_load, w_tx_ready;

    rx_state_e            r_rx_state, w_rx_state_nxt;
    logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_nxt, r_data_out, w_data_out_nxt;
    logic [BIT_CNT_W-1:0] r_rx_cnt, w_rx_cnt_nxt;
    logic                 r_rx_par, w_rx_par_nxt, r_stop_bad, w_stop_bad_nxt, w_stop_bad;
    logic                 r_data_ready, w_data_ready_nxt;
    logic                 r_par_err, w_par_err_nxt, r_stop_err, w_stop_err_nxt;
    logic                 w_rx, w_rx_tick, w_rx_load;

`ifdef UART_RX_SYNC_EN
    logic [1:0] r_rx_sync;
    always_ff @(posedge clk) begin
        if (reset) r_rx_sync <= 2'b11;
        else       r_rx_sync <= {r_rx_sync[0], rx};
    end
    assign w_rx = r_rx_sync[1];
`else
    assign w_rx = rx;
`endif

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clk(clk), .reset(reset), .load(w_tx_load), .load_half(1'b0), .tick(w_tx_tick)
    );
    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clk(clk), .reset(reset), .load(w_rx_load), .load_half(1'b1), .tick(w_rx_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state   <= TX_IDLE;
            r_tx_shift   <= '0;
            r_tx_cnt     <= '0;
            r_tx         <= 1'b1;
            r_tx_par     <= 1'b0;
            r_rx_state   <= RX_IDLE;
            r_rx_shift   <= '0;
            r_rx_cnt     <= '0;
            r_rx_par     <= 1'b0;
            r_stop_bad   <= 1'b0;
            r_data_out   <= '0;
            r_data_ready <= 1'b0;
            r_par_err    <= 1'b0;
            r_stop_err   <= 1'b0;
        end else begin
            r_tx_state   <= w_tx_state_nxt;
            r_tx_shift   <= w_tx_shift_nxt;
            r_tx_cnt     <= w_tx_cnt_nxt;
            r_tx         <= w_tx_nxt;
            r_tx_par     <= w_tx_par_nxt;
            r_rx_state   <= w_rx_state_nxt;
            r_rx_shift   <= w_rx_shift_nxt;
            r_rx_cnt     <= w_rx_cnt_nxt;
            r_rx_par     <= w_rx_par_nxt;
            r_stop_bad   <= w_stop_bad_nxt;
            r_data_out   <= w_data_out_nxt;
            r_data_ready <= w_data_ready_nxt;
            r_par_err    <= w_par_err_nxt;
            r_stop_err   <= w_stop_err_nxt;
        end
    end

    // Ready is raised during the final stop cycle so a waiting frame follows with no gap.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_cnt_nxt   = r_tx_cnt;
        w_tx_nxt       = r_tx;
        w_tx_par_nxt   = r_tx_par;
        w_tx_ready     = 1'b0;
        w_tx_load      = 1'b0;
        case (r_tx_state)
            TX_IDLE: w_tx_ready = 1'b1;
            TX_START: if (w_tx_tick) begin
                w_tx_state_nxt = TX_DATA;
                w_tx_nxt       = r_tx_shift[0];
                w_tx_shift_nxt = r_tx_shift >> 1;
                w_tx_cnt_nxt   = BIT_CNT_W'(1);
            end
            TX_DATA: if (w_tx_tick) begin
                if (r_tx_cnt == c_last_data) begin
                    w_tx_state_nxt = c_has_parity ? TX_PARITY : TX_STOP;
                    w_tx_nxt       = c_has_parity ? r_tx_par : 1'b1;
                    w_tx_cnt_nxt   = BIT_CNT_W'(1);
                end else begin
                    w_tx_nxt       = r_tx_shift[0];
                    w_tx_shift_nxt = r_tx_shift >> 1;
                    w_tx_cnt_nxt   = r_tx_cnt + 1'b1;
                end
            end
            TX_PARITY: if (w_tx_tick) begin
                w_tx_state_nxt = TX_STOP;
                w_tx_nxt       = 1'b1;
                w_tx_cnt_nxt   = BIT_CNT_W'(1);
            end
            TX_STOP: if (w_tx_tick) begin
                if (r_tx_cnt == c_last_stop) begin
                    w_tx_ready     = 1'b1;
                    w_tx_state_nxt = TX_IDLE;
                end else begin
                    w_tx_cnt_nxt   = r_tx_cnt + 1'b1;
                end
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
        if (w_tx_ready && tx_valid && tx_en) begin
            w_tx_state_nxt = TX_START;
            w_tx_nxt       = 1'b0;
            w_tx_shift_nxt = data_in;
            w_tx_par_nxt   = c_odd ^ (^data_in);
            w_tx_load      = 1'b1;
        end
    end

    always_comb begin
        w_rx_state_nxt   = r_rx_state;
        w_rx_shift_nxt   = r_rx_shift;
        w_rx_cnt_nxt     = r_rx_cnt;
        w_rx_par_nxt     = r_rx_par;
        w_stop_bad_nxt   = r_stop_bad;
        w_stop_bad       = r_stop_bad | ~w_rx;
        w_data_out_nxt   = r_data_out;
        w_data_ready_nxt = 1'b0;
        w_par_err_nxt    = r_par_err;
        w_stop_err_nxt   = r_stop_err;
        w_rx_load        = 1'b0;
        if (!rx_en) begin
            w_rx_state_nxt = RX_IDLE;
        end else begin
            case (r_rx_state)
                RX_IDLE: if (!w_rx) begin
                    w_rx_state_nxt = RX_START;
                    w_rx_load      = 1'b1;
                end
                RX_START: if (w_rx_tick) begin
                    w_rx_state_nxt = w_rx ? RX_IDLE : RX_DATA;
                    w_rx_cnt_nxt   = BIT_CNT_W'(1);
                end
                RX_DATA: if (w_rx_tick) begin
                    w_rx_shift_nxt = {w_rx, r_rx_shift[DATA_BITS-1:1]};
                    w_rx_cnt_nxt   = r_rx_cnt + 1'b1;
                    if (r_rx_cnt == c_last_data) begin
                        w_rx_state_nxt = c_has_parity ? RX_PARITY : RX_STOP;
                        w_rx_cnt_nxt   = BIT_CNT_W'(1);
                        w_stop_bad_nxt = 1'b0;
                    end
                end
                RX_PARITY: if (w_rx_tick) begin
                    w_rx_par_nxt   = w_rx;
                    w_rx_state_nxt = RX_STOP;
                    w_rx_cnt_nxt   = BIT_CNT_W'(1);
                end
                RX_STOP: if (w_rx_tick) begin
                    w_rx_cnt_nxt   = r_rx_cnt + 1'b1;
                    w_stop_bad_nxt = w_stop_bad;
                    if (r_rx_cnt == c_last_stop) begin
                        w_rx_state_nxt   = w_stop_bad ? RX_BREAK : RX_IDLE;
                        w_data_out_nxt   = r_rx_shift;
                        w_data_ready_nxt = 1'b1;
                        w_par_err_nxt    = c_has_parity & (^r_rx_shift ^ r_rx_par ^ c_odd);
                        w_stop_err_nxt   = w_stop_bad;
                    end
                end
                RX_BREAK: if (w_rx) w_rx_state_nxt = RX_IDLE;
                default: w_rx_state_nxt = RX_IDLE;
            endcase
        end
    end

    assign tx_ready     = w_tx_ready;
    assign tx           = r_tx;
    assign data_out     = r_data_out;
    assign data_ready   = r_data_ready;
    assign parity_error = r_par_err;
    assign stop_error   = r_stop_err;

endmodule
`default_nettype wire
